// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// operand-forwarding select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : hazard_pkg

// File: rtl/pipeline_hazard_controller_forward_unit.sv
// Combinational operand-forwarding select for one execute-stage source register.
// The memory stage holds the younger result, so it wins over writeback.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_execute,
  input  logic [REG_ADDR_W-1:0] i_rd_memory,
  input  logic                  i_wre_memory,
  input  logic [REG_ADDR_W-1:0] i_rd_writeback,
  input  logic                  i_wre_writeback,
  output logic [1:0]            o_forward_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign w_mem_hit = i_wre_memory && (i_rd_memory != '0) &&
                     (i_rd_memory == i_rs_execute);
  assign w_wb_hit  = i_wre_writeback && (i_rd_writeback != '0) &&
                     (i_rd_writeback == i_rs_execute);

  assign o_forward_sel = w_mem_hit ? FWD_MEM :
                         w_wb_hit  ? FWD_WB  : FWD_RF;

endmodule : forward_unit

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// branch flushes, memory-wait freezes with timeout, and operand forwarding.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_decode,
  input  logic [REG_ADDR_W-1:0] rs2_decode,
  input  logic [REG_ADDR_W-1:0] rs1_execute,
  input  logic [REG_ADDR_W-1:0] rs2_execute,
  input  logic [REG_ADDR_W-1:0] rd_execute,
  input  logic                  load_instruction,
  input  logic [REG_ADDR_W-1:0] rd_memory,
  input  logic [REG_ADDR_W-1:0] rd_writeback,
  input  logic                  wre_memory,
  input  logic                  wre_writeback,
  input  logic                  branch_taken_execute,
  input  logic                  mem_req_memory,
  input  logic                  mem_ready,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  nop_select,
  output logic                  flush_decode,
  output logic                  freeze_pipe,
  output logic [1:0]            forwardA_sel,
  output logic [1:0]            forwardB_sel,
  output logic                  mem_timeout,
  output logic [1:0]            hazard_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_count
`endif
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

  hz_state_t        r_state;
  hz_state_t        w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_next_wait_cnt;
  logic             r_timeout;
  logic             w_next_timeout;

  logic w_load_use;
  logic w_mem_busy;

  assign w_load_use = load_instruction && (rd_execute != '0) &&
                      ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));
  assign w_mem_busy = mem_req_memory && !mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      r_timeout  <= w_next_timeout;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_next_timeout  = r_timeout;
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    nop_select      = 1'b0;
    flush_decode    = 1'b0;
    freeze_pipe     = 1'b0;

    unique case (r_state)
      RUN: begin
        if (w_mem_busy) begin
          stall_fetch     = 1'b1;
          stall_decode    = 1'b1;
          freeze_pipe     = 1'b1;
          w_next_state    = MEM_WAIT;
          w_next_wait_cnt = CNT_ONE;
        end else if (branch_taken_execute) begin
          // The load-use consumer sits in decode and is flushed anyway.
          flush_decode = 1'b1;
          nop_select   = 1'b1;
        end else if (w_load_use) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          nop_select   = 1'b1;
        end
      end

      MEM_WAIT: begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        freeze_pipe  = 1'b1;
        if (mem_ready) begin
          w_next_state    = RUN;
          w_next_wait_cnt = '0;
        end else if (r_wait_cnt == CNT_MAX) begin
          w_next_timeout = 1'b1;
          w_next_state   = ERROR;
        end else begin
          w_next_wait_cnt = r_wait_cnt + CNT_ONE;
        end
      end

      ERROR: begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        freeze_pipe  = 1'b1;
      end

      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  assign mem_timeout  = r_timeout;
  assign hazard_state = r_state;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_forward_a (
    .i_rs_execute    (rs1_execute),
    .i_rd_memory     (rd_memory),
    .i_wre_memory    (wre_memory),
    .i_rd_writeback  (rd_writeback),
    .i_wre_writeback (wre_writeback),
    .o_forward_sel   (forwardA_sel)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_forward_b (
    .i_rs_execute    (rs2_execute),
    .i_rd_memory     (rd_memory),
    .i_wre_memory    (wre_memory),
    .i_rd_writeback  (rd_writeback),
    .i_wre_writeback (wre_writeback),
    .o_forward_sel   (forwardB_sel)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_fetch && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (flush_decode && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule : pipeline_hazard_controller

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed test-plan steps
// followed by randomized traffic compared against a behavioural model.
module tb_pipeline_hazard_controller;

  localparam int REG_ADDR_W   = 5;
  localparam int MEM_WAIT_MAX = 15;

  logic clk = 1'b0;
  logic reset;
  logic [REG_ADDR_W-1:0] rs1_decode, rs2_decode, rs1_execute, rs2_execute;
  logic [REG_ADDR_W-1:0] rd_execute, rd_memory, rd_writeback;
  logic load_instruction, wre_memory, wre_writeback;
  logic branch_taken_execute, mem_req_memory, mem_ready;
  logic stall_fetch, stall_decode, nop_select, flush_decode, freeze_pipe;
  logic [1:0] forwardA_sel, forwardB_sel, hazard_state;
  logic mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: is an access outstanding, how long has it waited,
  // has the controller given up on it.
  bit m_waiting, m_error, m_timeout;
  int m_elapsed;
  int m_stalls, m_flushes;

  pipeline_hazard_controller #(
    .REG_ADDR_W   (REG_ADDR_W),
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .rs1_decode           (rs1_decode),
    .rs2_decode           (rs2_decode),
    .rs1_execute          (rs1_execute),
    .rs2_execute          (rs2_execute),
    .rd_execute           (rd_execute),
    .load_instruction     (load_instruction),
    .rd_memory            (rd_memory),
    .rd_writeback         (rd_writeback),
    .wre_memory           (wre_memory),
    .wre_writeback        (wre_writeback),
    .branch_taken_execute (branch_taken_execute),
    .mem_req_memory       (mem_req_memory),
    .mem_ready            (mem_ready),
    .stall_fetch          (stall_fetch),
    .stall_decode         (stall_decode),
    .nop_select           (nop_select),
    .flush_decode         (flush_decode),
    .freeze_pipe          (freeze_pipe),
    .forwardA_sel         (forwardA_sel),
    .forwardB_sel         (forwardB_sel),
    .mem_timeout          (mem_timeout),
    .hazard_state         (hazard_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles         (stall_cycles),
    .flush_count          (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [REG_ADDR_W-1:0] rs);
    if (wre_memory && rd_memory != 0 && rd_memory == rs) return 2'd2;
    if (wre_writeback && rd_writeback != 0 && rd_writeback == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    rs1_decode = '0; rs2_decode = '0; rs1_execute = '0; rs2_execute = '0;
    rd_execute = '0; rd_memory = '0; rd_writeback = '0;
    load_instruction = 1'b0; wre_memory = 1'b0; wre_writeback = 1'b0;
    branch_taken_execute = 1'b0; mem_req_memory = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_error = 0; m_timeout = 0; m_elapsed = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // Called one time unit after a rising edge with inputs already driven:
  // compares all outputs against the model, then steps the model at the edge.
  task automatic cycle();
    bit lu, busy, e_stall, e_nop, e_flush, e_freeze;
    logic [1:0] e_state;
    #2;
    lu   = load_instruction && rd_execute != 0 &&
           (rd_execute == rs1_decode || rd_execute == rs2_decode);
    busy = mem_req_memory && !mem_ready;
    e_stall = 0; e_nop = 0; e_flush = 0; e_freeze = 0;
    if (m_error || m_waiting || busy) begin
      e_stall = 1; e_freeze = 1;
    end else if (branch_taken_execute) begin
      e_flush = 1; e_nop = 1;
    end else if (lu) begin
      e_stall = 1; e_nop = 1;
    end
    e_state = m_error ? 2'd2 : (m_waiting ? 2'd1 : 2'd0);
    check("stall_fetch",  16'(stall_fetch),  16'(e_stall));
    check("stall_decode", 16'(stall_decode), 16'(e_stall));
    check("nop_select",   16'(nop_select),   16'(e_nop));
    check("flush_decode", 16'(flush_decode), 16'(e_flush));
    check("freeze_pipe",  16'(freeze_pipe),  16'(e_freeze));
    check("forwardA_sel", 16'(forwardA_sel), 16'(fwd_ref(rs1_execute)));
    check("forwardB_sel", 16'(forwardB_sel), 16'(fwd_ref(rs2_execute)));
    check("mem_timeout",  16'(mem_timeout),  16'(m_timeout));
    check("hazard_state", 16'(hazard_state), 16'(e_state));
    if (e_stall) m_stalls++;
    if (e_flush) m_flushes++;
    @(posedge clk);
    if (m_waiting) begin
      if (mem_ready) begin
        m_waiting = 0;
      end else if (m_elapsed == MEM_WAIT_MAX) begin
        m_waiting = 0; m_error = 1; m_timeout = 1;
      end else begin
        m_elapsed++;
      end
    end else if (!m_error && busy) begin
      m_waiting = 1; m_elapsed = 1;
    end
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    idle();
    reset = 1'b0;
    #2;
    check("rst_state",   16'(hazard_state), 16'd0);
    check("rst_timeout", 16'(mem_timeout),  16'd0);
    check("rst_stall",   16'(stall_fetch),  16'd0);
    check("rst_freeze",  16'(freeze_pipe),  16'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset values with idle inputs.
    #1;
    check("reset_state",   16'(hazard_state), 16'd0);
    check("reset_fwdA",    16'(forwardA_sel), 16'd0);
    check("reset_fwdB",    16'(forwardB_sel), 16'd0);
    check("reset_timeout", 16'(mem_timeout),  16'd0);
    cycle();

    // Load x5 in execute, decode reads x5: one bubble.
    load_instruction = 1'b1; rd_execute = 5'd5; rs1_decode = 5'd5;
    #1;
    check("lu_stall", 16'(stall_fetch), 16'd1);
    check("lu_nop",   16'(nop_select),  16'd1);
    cycle();
    // Load moves to memory; bubble in execute, consumer now in execute.
    idle();
    rs1_execute = 5'd5; rd_memory = 5'd5; wre_memory = 1'b1;
    #1;
    check("lu_after_stall", 16'(stall_fetch),  16'd0);
    check("lu_after_fwdA",  16'(forwardA_sel), 16'd2);
    cycle();

    // Load to x0 never stalls.
    idle();
    load_instruction = 1'b1; rd_execute = 5'd0; rs1_decode = 5'd0;
    #1;
    check("lu_x0_stall", 16'(stall_fetch), 16'd0);
    cycle();

    // Branch with coincident load-use: flush wins, no stall.
    idle();
    load_instruction = 1'b1; rd_execute = 5'd3; rs2_decode = 5'd3;
    branch_taken_execute = 1'b1;
    #1;
    check("br_flush", 16'(flush_decode), 16'd1);
    check("br_nop",   16'(nop_select),   16'd1);
    check("br_stall", 16'(stall_fetch),  16'd0);
    cycle();

    // Forwarding priority and x0 exclusion.
    idle();
    rd_memory = 5'd7; rd_writeback = 5'd7; wre_memory = 1'b1; wre_writeback = 1'b1;
    rs2_execute = 5'd7;
    #1;
    check("fwdB_mem", 16'(forwardB_sel), 16'd2);
    cycle();
    wre_memory = 1'b0;
    #1;
    check("fwdB_wb", 16'(forwardB_sel), 16'd1);
    cycle();
    rd_memory = 5'd0; rd_writeback = 5'd0; wre_memory = 1'b1; rs1_execute = 5'd0;
    rs2_execute = 5'd0;
    cycle();

    // Stray mem_ready with no request is ignored.
    idle();
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    #1;
    check("stray_ready_state", 16'(hazard_state), 16'd0);
    cycle();

    // Access with mem_ready low three cycles, then high: four freeze cycles.
    idle();
    mem_req_memory = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1'b1;
    #1;
    check("wait_freeze_last", 16'(freeze_pipe),  16'd1);
    check("wait_state_last",  16'(hazard_state), 16'd1);
    cycle();
    idle();
    #1;
    check("wait_released", 16'(freeze_pipe), 16'd0);
    cycle();

    // Short access then a back-to-back one that never completes.
    mem_req_memory = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    #1;
    check("pre_timeout", 16'(mem_timeout), 16'd0);
    cycle();
    #1;
    check("timeout_flag",  16'(mem_timeout),  16'd1);
    check("timeout_state", 16'(hazard_state), 16'd2);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    cycle();

    // Reset while waiting.
    mem_req_memory = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if (m_error && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end
      rs1_decode  = 5'($urandom_range(0, 3));
      rs2_decode  = 5'($urandom_range(0, 3));
      rs1_execute = 5'($urandom_range(0, 3));
      rs2_execute = 5'($urandom_range(0, 3));
      rd_execute  = 5'($urandom_range(0, 3));
      rd_memory   = 5'($urandom_range(0, 3));
      rd_writeback = 5'($urandom_range(0, 3));
      load_instruction     = ($urandom_range(0, 9) < 4);
      wre_memory           = 1'($urandom_range(0, 1));
      wre_writeback        = 1'($urandom_range(0, 1));
      branch_taken_execute = ($urandom_range(0, 9) < 2);
      mem_req_memory       = ($urandom_range(0, 9) < 2);
      mem_ready            = (n % 150 > 100) ? 1'b0 : ($urandom_range(0, 9) < 5);
      cycle();
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cycles", stall_cycles, 16'(m_stalls));
    check("perf_flush_count",  flush_count,  16'(m_flushes));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_pipeline_hazard_controller
